// File: rtl/i2c_sensor_responder.sv
// i2c_sensor_responder
//   I2C target that stands in for the on-board pressure/temperature sensor so
//   the I2C master can be exercised in a closed loop. SCL/SDA are synchronised
//   and glitch-filtered on CLK_48MHZ. Reads are served from a flat register
//   image that is snapshotted at address match. Bytes written after the
//   pointer byte are handed out as strobed bytes.
//
//   Optional build macro: I2C_RESP_STRETCH_EN
//     Defined: SCL is held low for STRETCH_CYC cycles after each read ACK bit.
//     Not defined: SCL_OE is tied low.
//
// Ports
//   CLK_48MHZ  system clock
//   RESET_N    asynchronous active-low reset
//   SCL_IN     SCL pin level (asynchronous)
//   SDA_IN     SDA pin level (asynchronous)
//   SDA_OE     1 = pull SDA low
//   SCL_OE     1 = pull SCL low (clock stretch)
//   REG_DATA   register image, byte k = REG_DATA[8k+7:8k]
//   WR_DATA    last data byte written by the master
//   WR_PTR     register index that WR_DATA targets
//   WR_STROBE  one-cycle pulse, WR_DATA/WR_PTR valid
//   BUSY       high from address match until STOP or master NACK
module i2c_sensor_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h77,
    parameter int         NUM_REGS    = 10,
    parameter int         FILTER_LEN  = 3,
    parameter int         STRETCH_CYC = 48
) (
    input  logic                    CLK_48MHZ,
    input  logic                    RESET_N,
    input  logic                    SCL_IN,
    input  logic                    SDA_IN,
    output logic                    SDA_OE,
    output logic                    SCL_OE,
    input  logic [8*NUM_REGS-1:0]   REG_DATA,
    output logic [7:0]              WR_DATA,
    output logic [7:0]              WR_PTR,
    output logic                    WR_STROBE,
    output logic                    BUSY
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
    } state_t;

    localparam int FCW = $clog2(FILTER_LEN + 1);

    // Index 1 = SCL, index 0 = SDA.
    logic [1:0]     sync1, sync2, filt, filt_q;
    logic [FCW-1:0] fcnt [2];

    // A level change is accepted only after FILTER_LEN consecutive samples
    // disagree with the current filtered level.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1  <= {SCL_IN, SDA_IN};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + FCW'(1);
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_rise =  scl_f & ~filt_q[1];
    assign scl_fall = ~scl_f &  filt_q[1];
    assign start_c  = scl_f & filt_q[1] &  filt_q[0] & ~sda_f;
    assign stop_c   = scl_f & filt_q[1] & ~filt_q[0] &  sda_f;

    state_t             state, state_n;
    logic [2:0]         bit_cnt;
    logic [6:0]         shreg;
    logic [6:0]         tx_sh;     // remaining read bits, next one at [6]
    logic [7:0]         ptr;
    logic               rw;
    logic [8*NUM_REGS-1:0] image;

    logic [7:0] byte_in, ptr_inc, cur_byte, nxt_byte;
    logic       last_bit, addr_hit, ack_done;

    function automatic logic [7:0] byte_at(input logic [7:0] p,
                                           input logic [8*NUM_REGS-1:0] img);
        byte_at = 8'hFF;   // out-of-range reads
        for (int k = 0; k < NUM_REGS; k++)
            if (p == 8'(k)) byte_at = img[8*k +: 8];
    endfunction

    assign byte_in  = {shreg, sda_f};
    assign last_bit = scl_rise && (bit_cnt == 3'd7);
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR);
    assign ptr_inc  = (ptr == 8'(NUM_REGS - 1)) ? 8'h00 : ptr + 8'h01;
    assign cur_byte = byte_at(ptr, image);
    assign nxt_byte = byte_at(ptr_inc, image);
    // ACK phases: first SCL fall turns SDA on, second fall ends the ACK bit.
    assign ack_done = scl_fall && SDA_OE;

    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (stop_c)       state_n = ST_IDLE;
        else if (start_c) state_n = ST_ADDR;
        else begin
            case (state)
                ST_ADDR:      if (last_bit) state_n = addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
                ST_ADDR_ACK:  if (ack_done) state_n = rw ? ST_RDATA : ST_PTR;
                ST_PTR:       if (last_bit) state_n = ST_PTR_ACK;
                ST_PTR_ACK:   if (ack_done) state_n = ST_WDATA;
                ST_WDATA:     if (last_bit) state_n = ST_WDATA_ACK;
                ST_WDATA_ACK: if (ack_done) state_n = ST_WDATA;
                ST_RDATA:     if (scl_fall && bit_cnt == 3'd7) state_n = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda_f) state_n = ST_WAIT_STOP;   // master NACK
                    else if (scl_fall)     state_n = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            SDA_OE    <= 1'b0;
            WR_DATA   <= 8'h00;
            WR_PTR    <= 8'h00;
            WR_STROBE <= 1'b0;
            BUSY      <= 1'b0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            tx_sh     <= 7'd0;
            ptr       <= 8'h00;
            rw        <= 1'b0;
            image     <= '0;
        end else begin
            WR_STROBE <= 1'b0;
            if (start_c || stop_c) begin
                // Abort any byte in flight; the pointer is left untouched.
                bit_cnt <= 3'd0;
                SDA_OE  <= 1'b0;
                if (stop_c) BUSY <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_ADDR) begin
                                BUSY <= addr_hit;
                                rw   <= byte_in[0];
                                // Frozen copy keeps a multi-byte read coherent.
                                if (addr_hit && byte_in[0]) image <= REG_DATA;
                            end else if (state == ST_PTR) begin
                                ptr <= byte_in;
                            end else begin
                                WR_DATA   <= byte_in;
                                WR_PTR    <= ptr;
                                WR_STROBE <= 1'b1;
                                ptr       <= ptr_inc;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!SDA_OE) begin
                            SDA_OE <= 1'b1;
                        end else if (state == ST_ADDR_ACK && rw) begin
                            SDA_OE <= ~cur_byte[7];
                            tx_sh  <= cur_byte[6:0];
                        end else begin
                            SDA_OE <= 1'b0;
                        end
                    end
                    ST_RDATA: if (scl_fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            SDA_OE <= 1'b0;   // free SDA for the master's ACK
                        end else begin
                            SDA_OE <= ~tx_sh[6];
                            tx_sh  <= {tx_sh[5:0], 1'b0};
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise && sda_f) begin
                            BUSY <= 1'b0;
                        end else if (scl_fall) begin
                            ptr    <= ptr_inc;
                            SDA_OE <= ~nxt_byte[7];
                            tx_sh  <= nxt_byte[6:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_RESP_STRETCH_EN
    localparam int SCW = $clog2(STRETCH_CYC + 1);
    logic [SCW-1:0] str_cnt;
    logic           stretch_go;

    // Stretch starts on the SCL fall that ends a read ACK bit; the first data
    // bit is put on SDA in the same cycle, so it is set up before release.
    assign stretch_go = scl_fall &&
        ((state == ST_ADDR_ACK && SDA_OE && rw) || state == ST_RDATA_ACK);

    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            SCL_OE  <= 1'b0;
            str_cnt <= '0;
        end else if (stretch_go) begin
            SCL_OE  <= 1'b1;
            str_cnt <= SCW'(STRETCH_CYC - 1);
        end else if (SCL_OE) begin
            if (str_cnt == '0) SCL_OE <= 1'b0;
            else               str_cnt <= str_cnt - SCW'(1);
        end
    end
`else
    // No stretching; the comparison is constant false for any legal length.
    assign SCL_OE = (STRETCH_CYC < 0);
`endif

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Self-checking bench for i2c_sensor_responder: bit-banged I2C master on a
// wired-AND bus, randomized register images/pointers/data, and a reference
// model of the register pointer, snapshot image and write strobes.
module tb_i2c_sensor_responder;
    localparam int NR = 10;
    localparam int Q  = 12;   // quarter SCL period in clocks

    logic clk = 1'b0, rst_n = 1'b1, scl_drv = 1'b1, sda_drv = 1'b1;
    logic [8*NR-1:0] reg_data = '0;
    logic sda_oe, scl_oe, wr_strobe, busy;
    logic [7:0] wr_data, wr_ptr;
    logic scl_line, sda_line;

    assign scl_line = scl_drv & ~scl_oe;
    assign sda_line = sda_drv & ~sda_oe;

    i2c_sensor_responder #(.NUM_REGS(NR)) dut (
        .CLK_48MHZ(clk), .RESET_N(rst_n), .SCL_IN(scl_line), .SDA_IN(sda_line),
        .SDA_OE(sda_oe), .SCL_OE(scl_oe), .REG_DATA(reg_data),
        .WR_DATA(wr_data), .WR_PTR(wr_ptr), .WR_STROBE(wr_strobe), .BUSY(busy)
    );

    always #10 clk = ~clk;

    int checks = 0, errors = 0;
    int ptr_m = 0;
    logic [7:0] snap [NR];

    // Bus monitors: strobe log, SDA-on-cycle count, SDA stable while SCL high,
    // SCL_OE behaviour.
    logic [15:0] strb_log[$];
    int oe_cycles = 0, mon_err = 0, scl_hi_cnt = 0, run = 0;
    logic sda_oe_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strb_log.push_back({wr_ptr, wr_data});
        if (rst_n && sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;
        scl_hi_cnt  <= scl_line ? scl_hi_cnt + 1 : 0;
        sda_oe_prev <= sda_oe;
        if (rst_n && scl_hi_cnt > 8 && sda_oe !== sda_oe_prev) begin
            mon_err <= mon_err + 1;
            $display("FAIL sda_oe_stable: SDA_OE changed to %b while SCL high", sda_oe);
        end
`ifdef I2C_RESP_STRETCH_EN
        if (!rst_n) run <= 0;
        else if (scl_oe === 1'b1) run <= run + 1;
        else begin
            if (run != 0 && run != 48) begin
                mon_err <= mon_err + 1;
                $display("FAIL stretch_len: got %0d cycles want 48", run);
            end
            run <= 0;
        end
`else
        if (rst_n && scl_oe !== 1'b0) begin
            mon_err <= mon_err + 1;
            $display("FAIL scl_oe_tied: got %b want 0", scl_oe);
        end
`endif
    end

    function automatic int p_inc(input int p);
        return (p == NR - 1) ? 0 : (p + 1) % 256;
    endfunction

    function automatic logic [7:0] exp_rd(input int p);
        return (p < NR) ? snap[p] : 8'hFF;
    endfunction

    task automatic take_snap();
        for (int k = 0; k < NR; k++) snap[k] = reg_data[8*k +: 8];
    endtask

    task automatic rand_regs();
        for (int k = 0; k < NR; k++) reg_data[8*k +: 8] = 8'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        int t = 0;
        scl_drv = 1'b1;
        while (scl_line !== 1'b1 && t < 2000) begin
            wait_cyc(1);
            t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL scl_release: SCL still %b after %0d cycles, want 1", scl_line, t);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; scl_drv = 1'b1; wait_cyc(Q);
        sda_drv = 1'b0; wait_cyc(2*Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_rep_start();
        sda_drv = 1'b1; wait_cyc(Q);
        scl_high(); wait_cyc(2*Q);
        sda_drv = 1'b0; wait_cyc(2*Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_cyc(Q);
        scl_high(); wait_cyc(2*Q);
        sda_drv = 1'b1; wait_cyc(4*Q);
    endtask

    // One SCL pulse; g injects a one-cycle SDA glitch in the high phase.
    task automatic clock_bit(input logic b, input bit g, output logic r);
        sda_drv = b; wait_cyc(Q);
        scl_high(); wait_cyc(Q/2);
        if (g) begin
            sda_drv = ~b; wait_cyc(1); sda_drv = b;
        end else begin
            wait_cyc(1);
        end
        wait_cyc(Q/2);
        r = sda_line;
        wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit g, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], g, r);
        clock_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        clock_bit(~ack, 1'b0, r);
    endtask

    // Optional pointer write, then read n bytes (ACK all but the last).
    task automatic do_read(input bit set_ptr, input int p, input int n, input bit scramble);
        logic ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'hEE, 1'b0, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_w_ack: got %b want 1", ack); end
            write_byte(8'(p), 1'b0, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_ptr_ack: got %b want 1", ack); end
            ptr_m = p;
            i2c_rep_start();
        end
        write_byte(8'hEF, 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_r_ack: got %b want 1", ack); end
        take_snap();
        if (scramble) rand_regs();
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            checks++;
            if (d !== exp_rd(ptr_m)) begin
                errors++;
                $display("FAIL rd_data: ptr %0d got %h want %h", ptr_m, d, exp_rd(ptr_m));
            end
            if (i < n - 1) ptr_m = p_inc(ptr_m);
        end
        i2c_stop();
    endtask

    task automatic do_write(input int p, input int n, input logic [31:0] dat);
        logic ack;
        logic [7:0] d;
        logic [15:0] expq[$];
        int base = strb_log.size();
        i2c_start();
        write_byte(8'hEE, 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b want 1", ack); end
        write_byte(8'(p), 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_ptr_ack: got %b want 1", ack); end
        ptr_m = p;
        for (int i = 0; i < n; i++) begin
            d = dat[8*i +: 8];
            write_byte(d, 1'b0, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wr_data_ack: got %b want 1", ack); end
            expq.push_back({8'(ptr_m), d});
            ptr_m = p_inc(ptr_m);
        end
        i2c_stop();
        checks++;
        if (strb_log.size() - base != n) begin
            errors++;
            $display("FAIL wr_strobe_cnt: got %0d want %0d", strb_log.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (strb_log[base + i] !== expq[i]) begin
                    errors++;
                    $display("FAIL wr_strobe: got ptr/data %h want %h", strb_log[base + i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        wait_cyc(5);
        checks++;
        if ({sda_oe, scl_oe, wr_strobe, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000", {sda_oe, scl_oe, wr_strobe, busy});
        end
        checks++;
        if ({wr_data, wr_ptr} !== 16'h0000) begin
            errors++; $display("FAIL reset_wr: got %h want 0000", {wr_data, wr_ptr});
        end
        rst_n = 1'b1;
        wait_cyc(20);
        checks++;
        if ({sda_oe, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_idle: got %b want 00", {sda_oe, busy});
        end
        ptr_m = 0;
    endtask

    task automatic test_reg_read();
        logic ack;
        logic [7:0] d;
        for (int k = 0; k < NR; k++) reg_data[8*k +: 8] = 8'(8'h10 + k);
        i2c_start();
        write_byte(8'hEE, 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t1_addr_w_ack: got %b want 1", ack); end
        write_byte(8'h02, 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t1_ptr_ack: got %b want 1", ack); end
        ptr_m = 2;
        i2c_rep_start();
        write_byte(8'hEF, 1'b0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t1_addr_r_ack: got %b want 1", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
        take_snap();
        for (int i = 0; i < 3; i++) begin
            read_byte(i < 2, d);
            checks++;
            if (d !== exp_rd(ptr_m)) begin
                errors++; $display("FAIL t1_rd: byte %0d got %h want %h", i, d, exp_rd(ptr_m));
            end
            if (i < 2) ptr_m = p_inc(ptr_m);
        end
        wait_cyc(2);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL t1_nack_release: got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_nack_busy: got %b want 0", busy); end
        i2c_stop();
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int n0;
        logic [6:0] a;
        for (int it = 0; it < 4; it++) begin
            a = (it == 0) ? 7'h50 : 7'($urandom_range(0, 127));
            if (a == 7'h77) a = 7'h76;
            n0 = oe_cycles;
            i2c_start();
            write_byte({a, (it == 0) ? 1'b0 : 1'($urandom)}, 1'b0, ack);
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t2_noack: addr %h got ack %b want 0", a, ack); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy: got %b want 0", busy); end
            if (it == 0) write_byte(8'h55, 1'b0, ack);
            i2c_stop();
            checks++;
            if (oe_cycles != n0) begin
                errors++; $display("FAIL t2_sda_oe: got %0d active cycles want 0", oe_cycles - n0);
            end
        end
    endtask

    task automatic test_write_wrap();
        do_write(9, 2, 32'h0000_A55A);
        for (int it = 0; it < 5; it++)
            do_write($urandom_range(0, 12), $urandom_range(1, 4), $urandom);
    endtask

    task automatic test_snapshot();
        rand_regs();
        do_read(1'b1, 8'h0C, 2, 1'b0);
        for (int it = 0; it < 5; it++) begin
            rand_regs();
            do_read(1'($urandom), $urandom_range(0, 11), $urandom_range(1, 4), 1'b1);
        end
    endtask

    task automatic test_abort_glitch();
        logic ack, r;
        int base;
        rand_regs();
        base = strb_log.size();
        i2c_start();
        write_byte(8'hEE, 1'b0, ack);
        write_byte(8'h03, 1'b0, ack);
        ptr_m = 3;
        write_byte(8'hC3, 1'b1, ack);     // every bit glitched while SCL high
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t5_glitch_ack: got %b want 1", ack); end
        ptr_m = p_inc(ptr_m);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, r);
        i2c_stop();
        checks++;
        if (strb_log.size() - base != 1) begin
            errors++; $display("FAIL t5_strobe_cnt: got %0d want 1", strb_log.size() - base);
        end else begin
            checks++;
            if (strb_log[base] !== 16'h03C3) begin
                errors++; $display("FAIL t5_strobe: got %h want 03c3", strb_log[base]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
        do_read(1'b0, 0, 1, 1'b0);        // current-address read: pointer untouched by abort
    endtask

    task automatic test_reset_midread();
        logic ack;
        rand_regs();
        reg_data[7:0] = 8'h00;
        i2c_start();
        write_byte(8'hEE, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        i2c_rep_start();
        write_byte(8'hEF, 1'b0, ack);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL t6_driving: got %b want 1", sda_oe); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_oe, scl_oe, busy} !== 3'b000) begin
            errors++; $display("FAIL t6_async: got %b want 000", {sda_oe, scl_oe, busy});
        end
        scl_drv = 1'b1; wait_cyc(2);
        sda_drv = 1'b1; wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        ptr_m = 0;
        rand_regs();
        do_read(1'b0, 0, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_reg_read();
        test_addr_mismatch();
        test_write_wrap();
        test_snapshot();
        test_abort_glitch();
        test_reset_midread();
        wait_cyc(2);
        checks++;
        if (mon_err != 0) begin
            errors++; $display("FAIL bus_monitor: got %0d violations want 0", mon_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
